// File: rtl/whack_game_controller.sv
// Whack-a-mole game sequencer: start/end handshake with the game timer, LFSR mole spawn, hit scoring.
// Latency: StartKey edge -> ARM next cycle -> GameStart two cycles later; hits register one cycle after the switch edge.
// Backpressure: none; inputs are sampled every cycle and all outputs are registered.
// Ports: ClockIn/Reset (sync, active-high); StartKey, HitSw[NUM_MOLES], TimerDone in;
//        GameStart, GameDone, MoleLed[NUM_MOLES] (one-hot or 0), HitPulse, ScoreOnes/Tens/Hundreds (BCD) out.
module whack_game_controller #(
  parameter int         NUM_MOLES  = 10,
  parameter int         MOLE_TICKS = 25000000,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                 ClockIn,
  input  logic                 Reset,
  input  logic                 StartKey,
  input  logic [NUM_MOLES-1:0] HitSw,
  input  logic                 TimerDone,
  output logic                 GameStart,
  output logic                 GameDone,
  output logic [NUM_MOLES-1:0] MoleLed,
  output logic                 HitPulse,
  output logic [3:0]           ScoreOnes,
  output logic [3:0]           ScoreTens,
  output logic [3:0]           ScoreHundreds
);

  localparam int CW = $clog2(MOLE_TICKS);

  typedef enum logic [1:0] {IDLE, ARM, PLAY, DONE} state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic [NUM_MOLES-1:0] hit_q;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [CW-1:0]        life_q, life_d;

  logic                 game_start_d, game_done_d, hit_pulse_d;
  logic [NUM_MOLES-1:0] mole_d;
  logic [3:0]           ones_d, tens_d, hund_d;

  logic                 start_edge;
  logic [NUM_MOLES-1:0] hit_edge;
  logic                 hit;
  logic [4:0]           spawn_v, spawn_idx;
  logic [NUM_MOLES-1:0] spawn_led;
  logic                 score_sat;

  assign start_edge = StartKey & ~start_q;
  assign hit_edge   = HitSw & ~hit_q;
  // MoleLed is one-hot, so masking the edges with it both selects the
  // active switch and collapses multiple edges into a single hit.
  assign hit        = |(hit_edge & MoleLed);

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed never reaches 0.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Fold the 4-bit random value into range; NUM_MOLES >= 8 keeps one subtraction sufficient.
  assign spawn_v   = {1'b0, lfsr_q[3:0]};
  assign spawn_idx = (spawn_v < 5'(NUM_MOLES)) ? spawn_v : spawn_v - 5'(NUM_MOLES);
  assign spawn_led = {{(NUM_MOLES-1){1'b0}}, 1'b1} << spawn_idx;

  assign score_sat = (ScoreOnes == 4'd9) && (ScoreTens == 4'd9) && (ScoreHundreds == 4'd9);

  // State register and all registered outputs.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      hit_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      life_q        <= '0;
      GameStart     <= 1'b0;
      GameDone      <= 1'b0;
      MoleLed       <= '0;
      HitPulse      <= 1'b0;
      ScoreOnes     <= 4'd0;
      ScoreTens     <= 4'd0;
      ScoreHundreds <= 4'd0;
    end else begin
      state_q       <= state_d;
      start_q       <= StartKey;
      hit_q         <= HitSw;
      lfsr_q        <= lfsr_d;
      life_q        <= life_d;
      GameStart     <= game_start_d;
      GameDone      <= game_done_d;
      MoleLed       <= mole_d;
      HitPulse      <= hit_pulse_d;
      ScoreOnes     <= ones_d;
      ScoreTens     <= tens_d;
      ScoreHundreds <= hund_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = ARM;
      ARM:     state_d = PLAY;
      PLAY:    if (TimerDone) state_d = DONE;
      DONE:    if (start_edge) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    game_start_d = GameStart;
    game_done_d  = GameDone;
    mole_d       = MoleLed;
    hit_pulse_d  = 1'b0;
    ones_d       = ScoreOnes;
    tens_d       = ScoreTens;
    hund_d       = ScoreHundreds;
    life_d       = life_q;
    case (state_q)
      IDLE: begin
        game_start_d = 1'b0;
        game_done_d  = 1'b0;
      end
      ARM: begin
        ones_d       = 4'd0;
        tens_d       = 4'd0;
        hund_d       = 4'd0;
        mole_d       = '0;
        game_done_d  = 1'b0;
        game_start_d = 1'b1;
      end
      PLAY: begin
        // Priority: time-up beats spawn, hit beats lifetime expiry.
        if (TimerDone) begin
          game_start_d = 1'b0;
          game_done_d  = 1'b1;
          mole_d       = '0;
        end else if (MoleLed == '0) begin
          mole_d = spawn_led;
          life_d = CW'(MOLE_TICKS - 1);
        end else if (hit) begin
          mole_d      = '0;
          hit_pulse_d = 1'b1;
          if (!score_sat) begin
            if (ScoreOnes != 4'd9) begin
              ones_d = ScoreOnes + 4'd1;
            end else begin
              ones_d = 4'd0;
              if (ScoreTens != 4'd9) begin
                tens_d = ScoreTens + 4'd1;
              end else begin
                tens_d = 4'd0;
                hund_d = ScoreHundreds + 4'd1;
              end
            end
          end
        end else if (life_q == '0) begin
          mole_d = '0;
        end else begin
          life_d = life_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
